// File: rtl/gamma_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gamma_scheduler
// Brief    : Round-robin sharing of one non-pipelined multiplier_radix
//            quotient-estimate unit among NREQ requesters. Latches the
//            winner's operands, pulses en_multiplier once, waits the fixed
//            multiplier latency, then returns gamma tagged with the
//            requester id on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module gamma_scheduler #(
  parameter int mul_size = 80,
  parameter int radix    = 78,
  parameter int NREQ     = 4,
  parameter int MUL_LAT  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*mul_size-1:0]   req_m_prime,
  input  logic [NREQ*2*mul_size-1:0] req_a_prime,
  output logic [NREQ-1:0]            gnt,
  output logic                       en_multiplier,
  output logic [mul_size-1:0]        reg_m_prime,
  output logic [2*mul_size-1:0]      reg_a_prime,
  input  logic [radix-1:0]           gamma,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NREQ)-1:0]    out_id,
  output logic [radix-1:0]           out_gamma,
  output logic                       busy
);

  localparam int IDW  = $clog2(NREQ);
  localparam int CNTW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  // Probe index is one bit wider so rr_ptr + k (k <= NREQ) cannot overflow
  localparam logic [IDW:0]    NREQ_W   = (IDW+1)'(NREQ);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [IDW-1:0]          rr_ptr_q;
  logic [IDW-1:0]          id_q;
  logic [CNTW-1:0]         cnt_q;
  logic                    en_q;
  logic                    out_valid_q;
  logic [IDW-1:0]          out_id_q;
  logic [radix-1:0]        out_gamma_q;
  logic [mul_size-1:0]     reg_m_prime_q;
  logic [2*mul_size-1:0]   reg_a_prime_q;

  logic                    w_win_found;
  logic [IDW-1:0]          w_win_idx;
  logic [IDW:0]            w_probe;

  // Round-robin search: first asserted request after the last winner, wrapping
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_probe     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_probe = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (w_probe >= NREQ_W) begin
        w_probe = w_probe - NREQ_W;
      end
      if (!w_win_found && req[w_probe[IDW-1:0]]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_probe[IDW-1:0];
      end
    end
  end

  // Grant is only offered while idle; held low during reset
  always_comb begin
    gnt = '0;
    if (!rst && (state_q == S_IDLE) && w_win_found) begin
      gnt[w_win_idx] = 1'b1;
    end
  end

  // Control FSM: capture winner, single issue pulse, latency count, result handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= IDW'(NREQ - 1);
      id_q          <= '0;
      cnt_q         <= '0;
      en_q          <= 1'b0;
      out_valid_q   <= 1'b0;
      out_id_q      <= '0;
      out_gamma_q   <= '0;
      reg_m_prime_q <= '0;
      reg_a_prime_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_win_found) begin
            reg_m_prime_q <= req_m_prime[int'(w_win_idx)*mul_size +: mul_size];
            reg_a_prime_q <= req_a_prime[int'(w_win_idx)*2*mul_size +: 2*mul_size];
            id_q          <= w_win_idx;
            rr_ptr_q      <= w_win_idx;
            en_q          <= 1'b1;
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Multiplier has sampled the start pulse on this edge
          en_q    <= 1'b0;
          cnt_q   <= CNT_LOAD;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            out_gamma_q <= gamma;
            out_id_q    <= id_q;
            out_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          // Result and id stay frozen until the consumer takes them
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign en_multiplier = en_q;
  assign reg_m_prime   = reg_m_prime_q;
  assign reg_a_prime   = reg_a_prime_q;
  assign out_valid     = out_valid_q;
  assign out_id        = out_id_q;
  assign out_gamma     = out_gamma_q;
  assign busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gamma_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gamma_scheduler
// Brief    : Self-checking bench for gamma_scheduler with a behavioural
//            fixed-latency multiplier_radix model and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gamma_scheduler;

  localparam int MS  = 80;
  localparam int RX  = 78;
  localparam int NR  = 4;
  localparam int LAT = 3;
  localparam int IDW = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NR-1:0]       req;
  logic [NR*MS-1:0]    req_m_prime;
  logic [NR*2*MS-1:0]  req_a_prime;
  logic [NR-1:0]       gnt;
  logic                en_multiplier;
  logic [MS-1:0]       reg_m_prime;
  logic [2*MS-1:0]     reg_a_prime;
  logic [RX-1:0]       gamma;
  logic                out_valid;
  logic                out_ready;
  logic [IDW-1:0]      out_id;
  logic [RX-1:0]       out_gamma;
  logic                busy;

  int checks;
  int failures;
  int cyc;

  // Scoreboard and event logs
  logic [IDW-1:0] exp_id_q[$];
  logic [RX-1:0]  exp_g_q[$];
  logic [IDW-1:0] act_id_q[$];
  logic [RX-1:0]  act_g_q[$];
  logic [NR-1:0]  gnt_vec_q[$];
  int             gnt_cyc_q[$];
  int             resp_cyc_q[$];

  gamma_scheduler #(.mul_size(MS), .radix(RX), .NREQ(NR), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_m_prime(req_m_prime),
    .req_a_prime(req_a_prime), .gnt(gnt), .en_multiplier(en_multiplier),
    .reg_m_prime(reg_m_prime), .reg_a_prime(reg_a_prime), .gamma(gamma),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_gamma(out_gamma), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference quotient estimate with +1 and saturation to the gamma width
  function automatic logic [RX-1:0] golden(input logic [MS-1:0] m, input logic [2*MS-1:0] a);
    logic [255:0] mw, hi, lo, s;
    mw = 256'(m);
    hi = 256'(a[2*MS-1:MS]) * mw;
    lo = (256'(a[MS-1:0]) * mw) >> MS;
    s  = ((hi + lo) >> MS) + 256'd1;
    if (s[255:RX] != '0) s = {{(256-RX){1'b0}}, {RX{1'b1}}};
    return s[RX-1:0];
  endfunction

  function automatic logic [MS-1:0] rand_m();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[MS-1:0] >> $urandom_range(0, MS-1);
  endfunction

  function automatic logic [2*MS-1:0] rand_a();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t >> $urandom_range(0, 2*MS-1);
  endfunction

  // Multiplier model: result valid MUL_LAT edges after the edge sampling en
  int           mcnt;
  logic [RX-1:0] mres;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt <= 0;
      mres <= '0;
    end else if (en_multiplier) begin
      mcnt <= LAT - 1;
      mres <= golden(reg_m_prime, reg_a_prime);
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
    end
  end
  assign gamma = (mcnt == 0) ? mres : ~mres;

  // One clock: log grants (push expected) and handshakes (push actual)
  task automatic tick();
    int idx;
    @(negedge clk);
    if (gnt != '0) begin
      idx = 0;
      for (int i = NR-1; i >= 0; i--) if (gnt[i]) idx = i;
      gnt_vec_q.push_back(gnt);
      gnt_cyc_q.push_back(cyc);
      exp_id_q.push_back(IDW'(idx));
      exp_g_q.push_back(golden(req_m_prime[idx*MS +: MS], req_a_prime[idx*2*MS +: 2*MS]));
    end
    if (out_valid && out_ready) begin
      act_id_q.push_back(out_id);
      act_g_q.push_back(out_gamma);
      resp_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_sb();
    exp_id_q.delete(); exp_g_q.delete(); act_id_q.delete(); act_g_q.delete();
    gnt_vec_q.delete(); gnt_cyc_q.delete(); resp_cyc_q.delete();
  endtask

  task automatic test_reset();
    logic seen;
    rst = 1'b1; req = '0; out_ready = 1'b0; req_m_prime = '0; req_a_prime = '0;
    tick(); tick();
    checks++; if ({gnt, en_multiplier, out_valid, busy} !== 7'b0) begin failures++;
      $display("FAIL reset_ctrl: gnt/en/valid/busy=%b required 0", {gnt, en_multiplier, out_valid, busy}); end
    checks++; if ({out_id, out_gamma} !== '0) begin failures++;
      $display("FAIL reset_out: id=%0d gamma=%h required 0", out_id, out_gamma); end
    rst = 1'b0;
    tick();
    req_m_prime[MS +: MS] = rand_m();
    req_a_prime[2*MS +: 2*MS] = rand_a();
    req = 4'b0010;
    #1;
    checks++; if (gnt !== 4'b0010) begin failures++;
      $display("FAIL reset_first_gnt: gnt=%b required 0010", gnt); end
    tick(); req = '0;
    tick(); tick();
    checks++; if (busy !== 1'b1) begin failures++;
      $display("FAIL reset_busy_wait: busy=%b required 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({gnt, en_multiplier, out_valid, busy} !== 7'b0) begin failures++;
      $display("FAIL reset_async_ctrl: gnt/en/valid/busy=%b required 0", {gnt, en_multiplier, out_valid, busy}); end
    checks++; if ({reg_m_prime, reg_a_prime, out_id, out_gamma} !== '0) begin failures++;
      $display("FAIL reset_async_data: regs/out not cleared (reg_m=%h out_gamma=%h)", reg_m_prime, out_gamma); end
    tick();
    rst = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b0 || act_g_q.size() != 0) begin failures++;
      $display("FAIL reset_discard: out_valid seen=%b results=%0d required 0", seen, act_g_q.size()); end
    clear_sb();
  endtask

  task automatic test_single();
    logic [IDW-1:0] ai, ei;
    logic [RX-1:0]  ag, eg;
    clear_sb();
    out_ready = 1'b0;
    req_m_prime[2*MS +: MS] = 80'h1;
    req_a_prime[2*2*MS +: 2*MS] = 160'h1 << 78;
    req = 4'b0100;
    #1;
    checks++; if (gnt !== 4'b0100) begin failures++;
      $display("FAIL single_gnt: gnt=%b required 0100", gnt); end
    tick(); req = '0;
    for (int k = 1; k <= 5; k++) begin
      checks++; if (en_multiplier !== (k == 1)) begin failures++;
        $display("FAIL single_en: T+%0d en=%b required %b", k, en_multiplier, (k == 1)); end
      checks++; if (out_valid !== (k == 5)) begin failures++;
        $display("FAIL single_valid: T+%0d out_valid=%b required %b", k, out_valid, (k == 5)); end
      if (k < 5) tick();
    end
    checks++; if (out_id !== 2'd2 || out_gamma !== 78'd1) begin failures++;
      $display("FAIL single_result: id=%0d gamma=%h required id=2 gamma=1", out_id, out_gamma); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++;
      $display("FAIL single_accept: out_valid=%b busy=%b required 0 0", out_valid, busy); end
    while (act_g_q.size() != 0) begin
      ai = act_id_q.pop_front(); ag = act_g_q.pop_front();
      checks++;
      if (exp_g_q.size() == 0) begin failures++;
        $display("FAIL single_sb: unexpected result id=%0d gamma=%h", ai, ag); end
      else begin
        ei = exp_id_q.pop_front(); eg = exp_g_q.pop_front();
        if (ai !== ei || ag !== eg) begin failures++;
          $display("FAIL single_sb: got id=%0d gamma=%h required id=%0d gamma=%h", ai, ag, ei, eg); end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0]  ev;
    logic [IDW-1:0] ai, ei;
    logic [RX-1:0]  ag, eg;
    clear_sb();
    rst = 1'b1; #1; tick(); rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      req_m_prime[i*MS +: MS] = rand_m();
      req_a_prime[i*2*MS +: 2*MS] = rand_a();
    end
    req = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 60 && gnt_vec_q.size() < 5; k++) tick();
    req = '0;
    for (int k = 0; k < 40 && (busy || out_valid); k++) tick();
    checks++; if (gnt_vec_q.size() != 5 || resp_cyc_q.size() != 5) begin failures++;
      $display("FAIL rr_count: grants=%0d results=%0d required 5 5", gnt_vec_q.size(), resp_cyc_q.size()); end
    for (int i = 0; i < gnt_vec_q.size(); i++) begin
      ev = 4'b0001 << (i % NR);
      checks++; if (gnt_vec_q[i] !== ev) begin failures++;
        $display("FAIL rr_order: grant %0d gnt=%b required %b", i, gnt_vec_q[i], ev); end
    end
    for (int i = 1; i < gnt_cyc_q.size(); i++) begin
      checks++; if (gnt_cyc_q[i] - gnt_cyc_q[i-1] != LAT + 3) begin failures++;
        $display("FAIL rr_gnt_spacing: %0d cycles required %0d", gnt_cyc_q[i] - gnt_cyc_q[i-1], LAT + 3); end
    end
    for (int i = 1; i < resp_cyc_q.size(); i++) begin
      checks++; if (resp_cyc_q[i] - resp_cyc_q[i-1] != LAT + 3) begin failures++;
        $display("FAIL rr_resp_spacing: %0d cycles required %0d", resp_cyc_q[i] - resp_cyc_q[i-1], LAT + 3); end
    end
    while (act_g_q.size() != 0) begin
      ai = act_id_q.pop_front(); ag = act_g_q.pop_front();
      checks++;
      if (exp_g_q.size() == 0) begin failures++;
        $display("FAIL rr_sb: unexpected result id=%0d gamma=%h", ai, ag); end
      else begin
        ei = exp_id_q.pop_front(); eg = exp_g_q.pop_front();
        if (ai !== ei || ag !== eg) begin failures++;
          $display("FAIL rr_sb: got id=%0d gamma=%h required id=%0d gamma=%h", ai, ag, ei, eg); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [RX-1:0]  hold_g;
    logic [IDW-1:0] ai, ei;
    logic [RX-1:0]  ag, eg;
    int accept_cyc;
    clear_sb();
    out_ready = 1'b0;
    req_m_prime[3*MS +: MS] = rand_m();
    req_a_prime[3*2*MS +: 2*MS] = rand_a();
    req = 4'b1000;
    tick();
    req = 4'b0010;
    for (int k = 0; k < 20 && !out_valid; k++) tick();
    hold_g = (exp_g_q.size() != 0) ? exp_g_q[0] : ~out_gamma;
    for (int k = 0; k < 10; k++) begin
      checks++; if (out_valid !== 1'b1 || out_id !== 2'd3 || out_gamma !== hold_g || gnt !== 4'b0) begin failures++;
        $display("FAIL bp_hold: cycle %0d valid=%b id=%0d gamma=%h gnt=%b required 1 3 %h 0000",
                 k, out_valid, out_id, out_gamma, gnt, hold_g); end
      tick();
    end
    out_ready = 1'b1;
    accept_cyc = cyc;
    checks++; if (out_valid !== 1'b1) begin failures++;
      $display("FAIL bp_valid_at_accept: out_valid=%b required 1", out_valid); end
    tick();
    checks++; if (busy !== 1'b0 || gnt !== 4'b0010) begin failures++;
      $display("FAIL bp_next_grant: busy=%b gnt=%b required 0 0010", busy, gnt); end
    tick();
    req = '0;
    for (int k = 0; k < 40 && (busy || out_valid); k++) tick();
    checks++; if (gnt_vec_q.size() != 2 || gnt_cyc_q.size() != 2 || gnt_cyc_q[1] != accept_cyc + 1) begin failures++;
      $display("FAIL bp_grant_log: grants=%0d accept=%0d required 2 grants, second at %0d",
               gnt_vec_q.size(), accept_cyc, accept_cyc + 1); end
    while (act_g_q.size() != 0) begin
      ai = act_id_q.pop_front(); ag = act_g_q.pop_front();
      checks++;
      if (exp_g_q.size() == 0) begin failures++;
        $display("FAIL bp_sb: unexpected result id=%0d gamma=%h", ai, ag); end
      else begin
        ei = exp_id_q.pop_front(); eg = exp_g_q.pop_front();
        if (ai !== ei || ag !== eg) begin failures++;
          $display("FAIL bp_sb: got id=%0d gamma=%h required id=%0d gamma=%h", ai, ag, ei, eg); end
      end
    end
  endtask

  task automatic test_operand_hold();
    logic [MS-1:0]   m0;
    logic [2*MS-1:0] a0;
    logic [IDW-1:0]  ai, ei;
    logic [RX-1:0]   ag, eg;
    clear_sb();
    out_ready = 1'b1;
    m0 = rand_m() | 80'h1;
    a0 = {40'b0, rand_a()} | 160'h1;
    a0[2*MS-1 -: 40] = '0;
    req_m_prime[0 +: MS] = m0;
    req_a_prime[0 +: 2*MS] = a0;
    req = 4'b0001;
    tick(); req = '0;
    tick();
    tick();
    req_a_prime[0 +: 2*MS] = ~a0;
    #1;
    checks++; if (reg_a_prime !== a0 || reg_m_prime !== m0) begin failures++;
      $display("FAIL hold_regs: reg_a=%h reg_m=%h required %h %h", reg_a_prime, reg_m_prime, a0, m0); end
    for (int k = 0; k < 20 && !out_valid; k++) tick();
    checks++; if (reg_a_prime !== a0 || out_valid !== 1'b1) begin failures++;
      $display("FAIL hold_resp: reg_a=%h valid=%b required %h 1", reg_a_prime, out_valid, a0); end
    for (int k = 0; k < 40 && (busy || out_valid); k++) tick();
    checks++; if (act_g_q.size() != 1) begin failures++;
      $display("FAIL hold_count: results=%0d required 1", act_g_q.size()); end
    while (act_g_q.size() != 0) begin
      ai = act_id_q.pop_front(); ag = act_g_q.pop_front();
      checks++;
      if (exp_g_q.size() == 0) begin failures++;
        $display("FAIL hold_sb: unexpected result id=%0d gamma=%h", ai, ag); end
      else begin
        ei = exp_id_q.pop_front(); eg = exp_g_q.pop_front();
        if (ai !== ei || ag !== eg) begin failures++;
          $display("FAIL hold_sb: got id=%0d gamma=%h required id=%0d gamma=%h", ai, ag, ei, eg); end
      end
    end
  endtask

  task automatic test_random();
    int gp, granted, done, nwait;
    int wait_cnt[NR];
    logic [NR-1:0]  g;
    logic [IDW-1:0] ai, ei;
    logic [RX-1:0]  ag, eg;
    clear_sb();
    req = '0;
    gp = 0; granted = 0; done = 0;
    for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    for (int k = 0; k < 20000; k++) begin
      while (gp < gnt_vec_q.size()) begin
        g = gnt_vec_q[gp]; gp++; granted++;
        checks++; if (!$onehot(g)) begin failures++;
          $display("FAIL rand_onehot: gnt=%b required one-hot", g); end
        for (int i = 0; i < NR; i++) begin
          if (g[i]) begin
            checks++; if (wait_cnt[i] > NR - 1) begin failures++;
              $display("FAIL rand_starve: req %0d waited %0d grants required <= %0d", i, wait_cnt[i], NR - 1); end
            wait_cnt[i] = 0;
            req[i] = 1'b0;
          end else if (req[i]) begin
            wait_cnt[i]++;
          end
        end
      end
      while (act_g_q.size() != 0) begin
        ai = act_id_q.pop_front(); ag = act_g_q.pop_front();
        checks++; done++;
        if (exp_g_q.size() == 0) begin failures++;
          $display("FAIL rand_sb: unexpected result id=%0d gamma=%h", ai, ag); end
        else begin
          ei = exp_id_q.pop_front(); eg = exp_g_q.pop_front();
          if (ai !== ei || ag !== eg) begin failures++;
            $display("FAIL rand_sb: op %0d got id=%0d gamma=%h required id=%0d gamma=%h", done, ai, ag, ei, eg); end
        end
      end
      for (int j = 0; j < NR; j++) begin
        nwait = granted + $countones(req);
        if (!req[j] && nwait < 1000 && $urandom_range(0, 2) == 0) begin
          req_m_prime[j*MS +: MS] = rand_m();
          req_a_prime[j*2*MS +: 2*MS] = rand_a();
          req[j] = 1'b1;
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      if (done >= 1000 && req == '0 && !busy) break;
      tick();
    end
    checks++; if (done != 1000 || exp_g_q.size() != 0) begin failures++;
      $display("FAIL rand_total: results=%0d pending=%0d required 1000 0", done, exp_g_q.size()); end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1; req = '0; out_ready = 1'b0; req_m_prime = '0; req_a_prime = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_operand_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
